// File: rtl/divider.sv
// Multi-cycle DIV/IDIV unit: restoring division on magnitudes, one quotient bit per clock.
// Divides DX:AX (16-bit) or AX (8-bit) by the operand and reports #DE on overflow or /0.
module divider #(
  parameter bit ALLOW_MIN_NEG = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic        bit16,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        de
);

  typedef enum logic [1:0] {IDLE, PREP, LOOP, FIX} state_t;

  state_t      r_state;
  logic [31:0] r_dvd;
  logic [15:0] r_dvs;
  logic        r_signed;
  logic        r_is16;
  logic [15:0] r_rem;
  logic [15:0] r_low;
  logic [15:0] r_mag;
  logic [15:0] r_quo;
  logic [4:0]  r_count;
  logic        r_negQ;
  logic        r_negR;
  logic        r_early;

  logic        w_dvdNeg;
  logic        w_dvsNeg;
  logic [31:0] w_dvdRaw;
  logic [15:0] w_dvsRaw;
  logic [31:0] w_dvdMag;
  logic [15:0] w_dvsMag;
  logic [15:0] w_hiMag;
  logic [15:0] w_loMag;
  logic        w_early;
  logic [16:0] w_trial;
  logic        w_fits;
  logic [15:0] w_newRem;
  logic [15:0] w_limit;
  logic [15:0] w_mask;
  logic        w_qOvf;
  logic [15:0] w_qSigned;
  logic [15:0] w_rSigned;

  // Operand magnitudes and signs; signs only matter for IDIV.
  assign w_dvdNeg = r_signed & (r_is16 ? r_dvd[31] : r_dvd[15]);
  assign w_dvsNeg = r_signed & (r_is16 ? r_dvs[15] : r_dvs[7]);
  assign w_dvdRaw = r_is16 ? r_dvd : {16'h0000, r_dvd[15:0]};
  assign w_dvsRaw = r_is16 ? r_dvs : {8'h00, r_dvs[7:0]};
  assign w_dvdMag = !w_dvdNeg ? w_dvdRaw :
                    (r_is16 ? (~r_dvd + 32'd1) : {16'h0000, ~r_dvd[15:0] + 16'd1});
  assign w_dvsMag = !w_dvsNeg ? w_dvsRaw :
                    (r_is16 ? (~r_dvs + 16'd1) : {8'h00, ~r_dvs[7:0] + 8'd1});

  // The high half seeds the partial remainder; the low half is shifted in MSB-first.
  // Left-justifying the 8-bit low half lets the loop always take bit 15.
  assign w_hiMag = r_is16 ? w_dvdMag[31:16] : {8'h00, w_dvdMag[15:8]};
  assign w_loMag = r_is16 ? w_dvdMag[15:0]  : {w_dvdMag[7:0], 8'h00};
  assign w_early = (w_dvsMag == 16'h0000) || (w_hiMag >= w_dvsMag);

  // One restoring step: the extra top bit of the trial keeps the shifted-out carry.
  assign w_trial  = {r_rem, r_low[15]};
  assign w_fits   = (w_trial >= {1'b0, r_mag});
  assign w_newRem = w_fits ? (w_trial[15:0] - r_mag) : w_trial[15:0];

  // Signed range check and sign restoration for the final result.
  assign w_limit   = r_is16 ? 16'h8000 : 16'h0080;
  assign w_mask    = r_is16 ? 16'hFFFF : 16'h00FF;
  assign w_qOvf    = r_signed && (r_negQ ?
                       ((r_quo > w_limit) || ((r_quo == w_limit) && !ALLOW_MIN_NEG)) :
                       (r_quo >= w_limit));
  assign w_qSigned = (r_negQ ? (~r_quo + 16'd1) : r_quo) & w_mask;
  assign w_rSigned = (r_negR ? (~r_rem + 16'd1) : r_rem) & w_mask;

  // Sequencer and datapath: accept, prepare magnitudes, iterate, then fix signs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_signed  <= 1'b0;
      r_is16    <= 1'b0;
      r_rem     <= '0;
      r_low     <= '0;
      r_mag     <= '0;
      r_quo     <= '0;
      r_count   <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_early   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      de        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !done) begin
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            r_signed <= signed_op;
            r_is16   <= bit16;
            busy     <= 1'b1;
            de       <= 1'b0;
            r_state  <= PREP;
          end
        end
        PREP: begin
          r_rem   <= w_hiMag;
          r_low   <= w_loMag;
          r_mag   <= w_dvsMag;
          r_quo   <= '0;
          r_negQ  <= w_dvdNeg ^ w_dvsNeg;
          r_negR  <= w_dvdNeg;
          r_early <= w_early;
          r_count <= r_is16 ? 5'd16 : 5'd8;
          r_state <= LOOP;
        end
        LOOP: begin
          if (r_early) begin
            de      <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_rem   <= w_newRem;
            r_low   <= {r_low[14:0], 1'b0};
            r_quo   <= {r_quo[14:0], w_fits};
            r_count <= r_count - 5'd1;
            if (r_count == 5'd1) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          if (w_qOvf) begin
            de <= 1'b1;
          end else begin
            quotient  <= w_qSigned;
            remainder <= w_rSigned;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Bench for divider: two instances (ALLOW_MIN_NEG=0 and 1) share stimulus and are
// checked every cycle against an arithmetic model, plus literal expected values.
module tb_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signedOp;
  logic        bit16;
  logic [31:0] dividend;
  logic [15:0] divisor;

  logic        busyO [2];
  logic        doneO [2];
  logic        deO   [2];
  logic [15:0] quoO  [2];
  logic [15:0] remO  [2];

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  // Model state
  int          mCnt    = 0;
  int          mLat    = 0;
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;
  logic        expDe [2] = '{1'b0, 1'b0};
  logic [15:0] expQ  [2] = '{16'h0, 16'h0};
  logic [15:0] expR  [2] = '{16'h0, 16'h0};
  logic        pDe   [2];
  logic [15:0] pQ    [2];
  logic [15:0] pR    [2];

  divider #(.ALLOW_MIN_NEG(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .signed_op(signedOp), .bit16(bit16),
    .dividend(dividend), .divisor(divisor), .busy(busyO[0]), .done(doneO[0]),
    .quotient(quoO[0]), .remainder(remO[0]), .de(deO[0])
  );

  divider #(.ALLOW_MIN_NEG(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .signed_op(signedOp), .bit16(bit16),
    .dividend(dividend), .divisor(divisor), .busy(busyO[1]), .done(doneO[1]),
    .quotient(quoO[1]), .remainder(remO[1]), .de(deO[1])
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Result of a division computed with plain integer arithmetic.
  task automatic modelCompute(input logic s, input logic b16, input logic [31:0] dd,
                              input logic [15:0] dv);
    longint a, b, q, r, magQ, half;
    int n;
    logic [15:0] mask;
    bit early;
    n    = b16 ? 16 : 8;
    mask = b16 ? 16'hFFFF : 16'h00FF;
    if (s) begin
      a = b16 ? longint'($signed(dd)) : longint'($signed(dd[15:0]));
      b = b16 ? longint'($signed(dv)) : longint'($signed(dv[7:0]));
    end else begin
      a = b16 ? {32'h0, dd} : {48'h0, dd[15:0]};
      b = b16 ? {48'h0, dv} : {56'h0, dv[7:0]};
    end
    early = 1'b0;
    q = 0;
    r = 0;
    if (b == 0) begin
      early = 1'b1;
    end else begin
      magQ  = (a < 0 ? -a : a) / (b < 0 ? -b : b);
      early = (magQ >= (longint'(1) << n));
      q = a / b;
      r = a % b;
    end
    half = longint'(1) << (n - 1);
    mLat = early ? 2 : n + 2;
    for (int p = 0; p < 2; p++) begin
      if (early)  pDe[p] = 1'b1;
      else if (s) pDe[p] = (q > half - 1) || (q < -half) || ((q == -half) && (p == 0));
      else        pDe[p] = 1'b0;
      pQ[p] = 16'(q) & mask;
      pR[p] = 16'(r) & mask;
    end
  endtask

  // Cycle-level model of what the outputs must show after each rising edge.
  always @(posedge clock) begin
    bit wasDone;
    if (reset) begin
      mCnt    = 0;
      expBusy = 1'b0;
      expDone = 1'b0;
      for (int p = 0; p < 2; p++) begin
        expDe[p] = 1'b0;
        expQ[p]  = 16'h0;
        expR[p]  = 16'h0;
      end
    end else begin
      wasDone = expDone;
      expDone = 1'b0;
      if (mCnt > 0) begin
        mCnt--;
        if (mCnt == 0) begin
          expBusy = 1'b0;
          expDone = 1'b1;
          for (int p = 0; p < 2; p++) begin
            expDe[p] = pDe[p];
            if (!pDe[p]) begin
              expQ[p] = pQ[p];
              expR[p] = pR[p];
            end
          end
        end
      end else if (start && !wasDone) begin
        modelCompute(signedOp, bit16, dividend, divisor);
        mCnt    = mLat;
        expBusy = 1'b1;
        for (int p = 0; p < 2; p++) expDe[p] = 1'b0;
      end
    end
  end

  // Compare both instances with the model every cycle, away from the rising edge.
  always @(negedge clock) begin
    if (cmpEn) begin
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("busy[%0d]", p), 32'(busyO[p]), 32'(expBusy));
        checkOutput($sformatf("done[%0d]", p), 32'(doneO[p]), 32'(expDone));
        checkOutput($sformatf("de[%0d]", p), 32'(deO[p]), 32'(expDe[p]));
        checkOutput($sformatf("quotient[%0d]", p), 32'(quoO[p]), 32'(expQ[p]));
        checkOutput($sformatf("remainder[%0d]", p), 32'(remO[p]), 32'(expR[p]));
      end
    end
  end

  // Present one division, scramble inputs after acceptance and measure latency.
  task automatic applyStimulus(input string nm, input logic s, input logic b16,
                               input logic [31:0] dd, input logic [15:0] dv,
                               input int expLat, input bit pulseMid, input bit backToBack);
    int k;
    @(negedge clock);
    start = 1'b1; signedOp = s; bit16 = b16; dividend = dd; divisor = dv;
    @(negedge clock);
    start = 1'b0; signedOp = ~s; bit16 = ~b16; dividend = 32'hA5A5_5A5A; divisor = 16'h3C3C;
    k = 0;
    while (doneO[1] !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
      if (pulseMid && k == 3) begin
        start = 1'b1; dividend = 32'h0000_0001; divisor = 16'h0001;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput({nm, " latency"}, 32'(k), 32'(expLat));
    if (backToBack) begin
      start = 1'b1; signedOp = 1'b0; bit16 = 1'b0; dividend = 32'h0000_0064; divisor = 16'h0005;
      @(negedge clock);
      start = 1'b0;
      checkOutput({nm, " back-to-back busy"}, 32'(busyO[1]), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; signedOp = 1'b0; bit16 = 1'b0;
    dividend = 32'h0; divisor = 16'h0;
    @(negedge clock);
    cmpEn = 1'b1;
    checkOutput("reset busy", 32'(busyO[1]), 32'd0);
    checkOutput("reset done", 32'(doneO[1]), 32'd0);
    checkOutput("reset de", 32'(deO[1]), 32'd0);
    checkOutput("reset quotient", 32'(quoO[1]), 32'h0);
    checkOutput("reset remainder", 32'(remO[1]), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] DIV16 0x00010005 / 0x0010");
    applyStimulus("div16", 1'b0, 1'b1, 32'h0001_0005, 16'h0010, 18, 1'b0, 1'b1);
    checkOutput("div16 q", 32'(quoO[1]), 32'h1000);
    checkOutput("div16 r", 32'(remO[1]), 32'h0005);
    checkOutput("div16 de", 32'(deO[1]), 32'd0);

    $display("[TB] IDIV8 -100 / 7 with start pulsed while busy");
    applyStimulus("idiv8", 1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 10, 1'b1, 1'b0);
    checkOutput("idiv8 q", 32'(quoO[1]), 32'h00F2);
    checkOutput("idiv8 r", 32'(remO[1]), 32'h00FE);
    checkOutput("idiv8 de", 32'(deO[1]), 32'd0);

    $display("[TB] DIV16 by zero");
    applyStimulus("div0", 1'b0, 1'b1, 32'h1234_5678, 16'h0000, 2, 1'b0, 1'b0);
    checkOutput("div0 de", 32'(deO[1]), 32'd1);
    checkOutput("div0 q held", 32'(quoO[1]), 32'h00F2);
    checkOutput("div0 r held", 32'(remO[1]), 32'h00FE);

    $display("[TB] DIV8 0x1000 / 0x10 overflow");
    applyStimulus("div8ovf", 1'b0, 1'b0, 32'h0000_1000, 16'h0010, 2, 1'b0, 1'b0);
    checkOutput("div8ovf de", 32'(deO[1]), 32'd1);
    checkOutput("div8ovf q held", 32'(quoO[1]), 32'h00F2);

    $display("[TB] IDIV8 100 / -7");
    applyStimulus("idiv8neg", 1'b1, 1'b0, 32'h0000_0064, 16'h00F9, 10, 1'b0, 1'b0);
    checkOutput("idiv8neg q", 32'(quoO[1]), 32'h00F2);
    checkOutput("idiv8neg r", 32'(remO[1]), 32'h0002);

    $display("[TB] IDIV16 -32768 / 1");
    applyStimulus("minneg", 1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, 18, 1'b0, 1'b0);
    checkOutput("minneg q allow", 32'(quoO[1]), 32'h8000);
    checkOutput("minneg r allow", 32'(remO[1]), 32'h0000);
    checkOutput("minneg de allow", 32'(deO[1]), 32'd0);
    checkOutput("minneg de strict", 32'(deO[0]), 32'd1);
    checkOutput("minneg q strict held", 32'(quoO[0]), 32'h00F2);

    $display("[TB] IDIV16 -32768 / -1");
    applyStimulus("posovf", 1'b1, 1'b1, 32'hFFFF_8000, 16'hFFFF, 18, 1'b0, 1'b0);
    checkOutput("posovf de", 32'(deO[1]), 32'd1);
    checkOutput("posovf q held", 32'(quoO[1]), 32'h8000);

    $display("[TB] reset during DIV16");
    @(negedge clock);
    start = 1'b1; signedOp = 1'b0; bit16 = 1'b1; dividend = 32'h0001_0005; divisor = 16'h0010;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort busy", 32'(busyO[1]), 32'd0);
    checkOutput("abort quotient", 32'(quoO[1]), 32'h0);
    checkOutput("abort remainder", 32'(remO[1]), 32'h0);
    checkOutput("abort de", 32'(deO[1]), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("abort no done", 32'(doneO[1]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
